// File: rtl/rtmc_pkg.sv
// Shared types and width helpers for the rtmc step sequencer.
// The command struct carries the widest supported delay; narrower DW values zero-extend into it.
package rtmc_pkg;

    localparam int unsigned RTMC_SEQ_DW_DEFAULT = 16;
    localparam int unsigned RTMC_SEQ_DW_MAX     = 32;
    localparam int unsigned RTMC_SEQ_HDR_W      = 11;

    // Width of one packed command word: {wait, wsel[1:0], pattern[7:0], delay[DW-1:0]}.
    function automatic int unsigned rtmc_seq_cmd_width(input int unsigned dw);
        return dw + RTMC_SEQ_HDR_W;
    endfunction

    localparam int unsigned RTMC_SEQ_CMD_W = rtmc_seq_cmd_width(RTMC_SEQ_DW_DEFAULT);

    typedef enum logic [1:0] {
        StIdle     = 2'd0,
        StWaitTrig = 2'd1,
        StHold     = 2'd2
    } rtmc_seq_state_e;

    typedef struct packed {
        logic                       trig_wait;
        logic [1:0]                 wsel;
        logic [7:0]                 pattern;
        logic [RTMC_SEQ_DW_MAX-1:0] delay;
    } rtmc_seq_cmd_t;

endpackage

// File: rtl/rtmc_cmd_fifo.sv
// Synchronous command FIFO with flush; head entry is presented combinationally on o_data.
// Full and empty are decoded from the occupancy counter, so pointers wrap freely.
module rtmc_cmd_fifo #(
    parameter  int unsigned DEPTH = 4,
    parameter  int unsigned WIDTH = 27,
    localparam int unsigned AW    = $clog2(DEPTH),
    localparam int unsigned LW    = AW + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic             i_flush,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty,
    output logic [LW-1:0]    o_level
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [LW-1:0]    r_level;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_level == LW'(DEPTH));
    assign o_empty = (r_level == '0);
    assign o_level = r_level;
    assign o_data  = r_mem[r_rptr];

    // Flush wins over a same-cycle push or pop.
    assign w_push = i_push & ~o_full & ~i_flush;
    assign w_pop  = i_pop & ~o_empty & ~i_flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
        end else if (i_flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr] <= i_data;
    end

endmodule

// File: rtl/rtmc_step_sequencer.sv
// Timed command sequencer driving the rtmc mc pins with cycle-exact hold times.
// Optional GPI trigger wait per command is compiled in with RTMC_SEQ_TRIG_EN.
module rtmc_step_sequencer
    import rtmc_pkg::*;
#(
    parameter  int unsigned DEPTH = 4,
    parameter  int unsigned DW    = 16,
    localparam int unsigned CW    = rtmc_seq_cmd_width(DW),
    localparam int unsigned LW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_cmd_valid,
    output logic          o_cmd_ready,
    input  logic [CW-1:0] i_cmd_data,
    input  logic          i_start,
    input  logic          i_abort,
    input  logic [3:0]    i_gpi,
    output logic [7:0]    o_mc,
    output logic [7:0]    o_mc_oe,
    output logic          o_busy,
    output logic          o_done,
    output logic [LW-1:0] o_level
);

    rtmc_seq_state_e r_state;
    rtmc_seq_state_e w_state_next;
    logic [DW-1:0]   r_cnt;
    logic [DW-1:0]   w_cnt_next;
    logic [7:0]      r_mc;
    logic [7:0]      w_mc_next;
    logic [7:0]      r_mc_oe;
    logic [7:0]      w_mc_oe_next;
    logic            r_done;
    logic            w_done_next;

    logic            w_push;
    logic            w_pop;
    logic            w_flush;
    logic            w_full;
    logic            w_empty;
    logic [CW-1:0]   w_fifo_dout;
    logic            w_dispatch;
    logic            w_apply;
    rtmc_seq_cmd_t   w_head;
    rtmc_seq_cmd_t   w_apply_cmd;
    logic            w_unused;

    // A push in the abort cycle is dropped along with the flushed contents.
    assign w_push      = i_cmd_valid & ~w_full & ~i_abort;
    assign o_cmd_ready = ~w_full;

    rtmc_cmd_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (CW)
    ) u_cmd_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (w_flush),
        .i_data  (i_cmd_data),
        .o_data  (w_fifo_dout),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_level (o_level)
    );

    always_comb begin
        w_head                = '0;
        w_head.trig_wait      = w_fifo_dout[CW-1];
        w_head.wsel           = w_fifo_dout[CW-2 -: 2];
        w_head.pattern        = w_fifo_dout[DW +: 8];
        w_head.delay[DW-1:0]  = w_fifo_dout[DW-1:0];
    end

`ifdef RTMC_SEQ_TRIG_EN
    logic [3:0]    r_sync1;
    logic [3:0]    r_sync2;
    logic [3:0]    r_sync3;
    logic [3:0]    w_rise;
    logic          r_trig;
    logic          w_pend_load;
    rtmc_seq_cmd_t r_pend;

    assign w_rise = r_sync2 & ~r_sync3;

    // Registered edge keeps mc three edges behind the first GPI sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_sync3 <= '0;
            r_trig  <= 1'b0;
            r_pend  <= '0;
        end else begin
            r_sync1 <= i_gpi;
            r_sync2 <= r_sync1;
            r_sync3 <= r_sync2;
            r_trig  <= (r_state == StWaitTrig) & w_rise[r_pend.wsel];
            if (w_pend_load) r_pend <= w_head;
        end
    end

    assign w_unused = ^{w_apply_cmd, r_pend.trig_wait};
`else
    assign w_unused = ^{i_gpi, w_apply_cmd, w_head};
`endif

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_mc_next    = r_mc;
        w_mc_oe_next = r_mc_oe;
        w_done_next  = 1'b0;
        w_pop        = 1'b0;
        w_flush      = 1'b0;
        w_dispatch   = 1'b0;
        w_apply      = 1'b0;
        w_apply_cmd  = '0;
`ifdef RTMC_SEQ_TRIG_EN
        w_pend_load  = 1'b0;
`endif
        if (i_abort) begin
            w_state_next = StIdle;
            w_flush      = 1'b1;
            w_mc_next    = '0;
            w_mc_oe_next = '0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (i_start && !w_empty) begin
                        w_pop      = 1'b1;
                        w_dispatch = 1'b1;
                    end
                end
                StHold: begin
                    if (r_cnt == '0) begin
                        if (!w_empty) begin
                            w_pop      = 1'b1;
                            w_dispatch = 1'b1;
                        end else begin
                            w_state_next = StIdle;
                            w_done_next  = 1'b1;
                        end
                    end else begin
                        w_cnt_next = r_cnt - 1'b1;
                    end
                end
                StWaitTrig: begin
`ifdef RTMC_SEQ_TRIG_EN
                    if (r_trig) begin
                        w_apply     = 1'b1;
                        w_apply_cmd = r_pend;
                    end
`else
                    w_state_next = StIdle;
`endif
                end
                default: w_state_next = StIdle;
            endcase

            if (w_dispatch) begin
`ifdef RTMC_SEQ_TRIG_EN
                if (w_head.trig_wait) begin
                    w_state_next = StWaitTrig;
                    w_pend_load  = 1'b1;
                end else begin
                    w_apply     = 1'b1;
                    w_apply_cmd = w_head;
                end
`else
                w_apply     = 1'b1;
                w_apply_cmd = w_head;
`endif
            end

            if (w_apply) begin
                w_state_next = StHold;
                w_mc_next    = w_apply_cmd.pattern;
                w_mc_oe_next = 8'hFF;
                w_cnt_next   = w_apply_cmd.delay[DW-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
            r_cnt   <= '0;
            r_mc    <= '0;
            r_mc_oe <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_mc    <= w_mc_next;
            r_mc_oe <= w_mc_oe_next;
            r_done  <= w_done_next;
        end
    end

    assign o_mc    = r_mc;
    assign o_mc_oe = r_mc_oe;
    assign o_busy  = (r_state != StIdle);
    assign o_done  = r_done;

endmodule
